// File: rtl/key_sense_filter.sv
// key_sense_filter: synchronizes and debounces raw light-sensor key inputs.
// Each channel runs its own 4-state debounce FSM. The block produces clean key
// levels, single-cycle press/release pulses, and a registered lowest-index
// active-key encoding.
module key_sense_filter #(
    parameter int NUM_KEYS          = 8,
    parameter int DEBOUNCE_CYCLES   = 500000,
    parameter int CNT_W             = 20,
    parameter int SENSE_ACTIVE_HIGH = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NUM_KEYS-1:0] raw_key,
    output logic [NUM_KEYS-1:0] key_on,
    output logic [NUM_KEYS-1:0] key_press,
    output logic [NUM_KEYS-1:0] key_release,
    output logic                any_key,
    output logic [3:0]          active_idx
);

    // Terminal count: the transition fires when cnt reaches this value while stable.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ARMING    = 2'd1,
        HELD      = 2'd2,
        RELEASING = 2'd3
    } state_t;

    logic [NUM_KEYS-1:0] sync1_reg;
    logic [NUM_KEYS-1:0] sync2_reg;
    logic [NUM_KEYS-1:0] sense;

    // Two-flop synchronizer on every raw sensor line.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_reg <= '0;
            sync2_reg <= '0;
        end else begin
            sync1_reg <= raw_key;
            sync2_reg <= sync1_reg;
        end
    end

    // Normalize polarity so that sense=1 always means "pressed".
    assign sense = (SENSE_ACTIVE_HIGH != 0) ? sync2_reg : ~sync2_reg;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_KEYS; gi++) begin : g_chan
            state_t           state_reg, state_next;
            logic [CNT_W-1:0] cnt_reg, cnt_next;
            logic             on_reg, on_next;
            logic             press_reg, press_next;
            logic             release_reg, release_next;

            // Channel state, counter and registered outputs.
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    state_reg   <= IDLE;
                    cnt_reg     <= '0;
                    on_reg      <= 1'b0;
                    press_reg   <= 1'b0;
                    release_reg <= 1'b0;
                end else begin
                    state_reg   <= state_next;
                    cnt_reg     <= cnt_next;
                    on_reg      <= on_next;
                    press_reg   <= press_next;
                    release_reg <= release_next;
                end
            end

            // Debounce decision. The counter restarts on every entry to a counting state,
            // so it cannot wrap.
            always_comb begin
                state_next   = state_reg;
                cnt_next     = cnt_reg;
                on_next      = on_reg;
                press_next   = 1'b0;
                release_next = 1'b0;
                case (state_reg)
                    IDLE: begin
                        if (sense[gi]) begin
                            state_next = ARMING;
                            cnt_next   = '0;
                        end
                    end
                    ARMING: begin
                        if (!sense[gi]) begin
                            state_next = IDLE;
                        end else if (cnt_reg == CNT_LAST) begin
                            state_next = HELD;
                            on_next    = 1'b1;
                            press_next = 1'b1;
                        end else begin
                            cnt_next = cnt_reg + 1'b1;
                        end
                    end
                    HELD: begin
                        if (!sense[gi]) begin
                            state_next = RELEASING;
                            cnt_next   = '0;
                        end
                    end
                    RELEASING: begin
                        if (sense[gi]) begin
                            state_next = HELD;
                        end else if (cnt_reg == CNT_LAST) begin
                            state_next   = IDLE;
                            on_next      = 1'b0;
                            release_next = 1'b1;
                        end else begin
                            cnt_next = cnt_reg + 1'b1;
                        end
                    end
                    default: begin
                        state_next = IDLE;
                        cnt_next   = '0;
                        on_next    = 1'b0;
                    end
                endcase
            end

            assign key_on[gi]      = on_reg;
            assign key_press[gi]   = press_reg;
            assign key_release[gi] = release_reg;
        end
    endgenerate

    logic       any_next;
    logic [3:0] idx_next;

    // Lowest-index priority encode of the current clean levels.
    always_comb begin
        any_next = |key_on;
        idx_next = '0;
        for (int i = NUM_KEYS - 1; i >= 0; i--) begin
            if (key_on[i]) begin
                idx_next = 4'(i);
            end
        end
    end

    // Summary outputs are registered, so they trail key_on by one cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            any_key    <= 1'b0;
            active_idx <= '0;
        end else begin
            any_key    <= any_next;
            active_idx <= idx_next;
        end
    end

endmodule

// File: tb/tb_key_sense_filter.sv
// Bench for key_sense_filter. It drives two instances: active-high with a
// debounce count of 4, and active-low with a debounce count of 1. A reference
// model runs at every clock edge and pushes the expected outputs for that edge
// into a queue. A monitor on the falling edge pops each entry and compares it
// with the outputs.
module tb_key_sense_filter;

    typedef struct packed {
        logic [7:0] on;
        logic [7:0] press;
        logic [7:0] rel;
        logic       any;
        logic [3:0] idx;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] raw_hi = 8'hFF;
    logic [7:0] raw_lo = 8'hFF;

    logic [7:0] on_hi, press_hi, rel_hi, on_lo, press_lo, rel_lo;
    logic       any_hi, any_lo;
    logic [3:0] idx_hi, idx_lo;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    key_sense_filter #(.NUM_KEYS(8), .DEBOUNCE_CYCLES(4), .CNT_W(8), .SENSE_ACTIVE_HIGH(1)) u_hi (
        .clk(clk), .rst(rst), .raw_key(raw_hi), .key_on(on_hi), .key_press(press_hi),
        .key_release(rel_hi), .any_key(any_hi), .active_idx(idx_hi)
    );

    key_sense_filter #(.NUM_KEYS(8), .DEBOUNCE_CYCLES(1), .CNT_W(4), .SENSE_ACTIVE_HIGH(0)) u_lo (
        .clk(clk), .rst(rst), .raw_key(raw_lo), .key_on(on_lo), .key_press(press_lo),
        .key_release(rel_lo), .any_key(any_lo), .active_idx(idx_lo)
    );

    // ---------------- reference model ----------------
    // A key's level flips once its synchronized sense value has differed from
    // the level for DEBOUNCE_CYCLES+1 consecutive edges.
    logic [7:0] m_level [2];
    logic [7:0] m_sync1 [2];
    logic [7:0] m_sync2 [2];
    int         m_run   [2][8];
    int         m_d     [2];
    exp_t       q_hi [$];
    exp_t       q_lo [$];
    exp_t       e_hi, e_lo;

    task automatic model_step(input int k, input logic [7:0] raw, input logic rn, output exp_t e);
        logic [7:0] s;
        logic [7:0] old;
        logic       found;
        e = '0;
        if (!rn) begin
            m_level[k] = '0;
            m_sync1[k] = '0;
            m_sync2[k] = '0;
            for (int c = 0; c < 8; c++) m_run[k][c] = 0;
            return;
        end
        old = m_level[k];
        s   = (k == 0) ? m_sync2[k] : ~m_sync2[k];
        for (int c = 0; c < 8; c++) begin
            if (s[c] != m_level[k][c]) begin
                m_run[k][c]++;
                if (m_run[k][c] == m_d[k] + 1) begin
                    m_level[k][c] = s[c];
                    m_run[k][c]   = 0;
                    if (s[c]) e.press[c] = 1'b1;
                    else      e.rel[c]   = 1'b1;
                end
            end else begin
                m_run[k][c] = 0;
            end
        end
        m_sync2[k] = m_sync1[k];
        m_sync1[k] = raw;
        e.on  = m_level[k];
        e.any = (old != 8'h00);
        found = 1'b0;
        for (int c = 0; c < 8; c++) begin
            if (old[c] && !found) begin
                e.idx = 4'(c);
                found = 1'b1;
            end
        end
    endtask

    initial begin
        m_d[0] = 4;
        m_d[1] = 1;
        for (int k = 0; k < 2; k++) begin
            m_level[k] = '0;
            m_sync1[k] = '0;
            m_sync2[k] = '0;
            for (int c = 0; c < 8; c++) m_run[k][c] = 0;
        end
    end

    // Model advances on each edge, using the same inputs the DUT samples there.
    always @(posedge clk) begin
        model_step(0, raw_hi, rst, e_hi);
        q_hi.push_back(e_hi);
        model_step(1, raw_lo, rst, e_lo);
        q_lo.push_back(e_lo);
    end

    // ---------------- monitor / scoreboard ----------------
    task automatic cmp(input string name, input int inst, input logic [7:0] act, input logic [7:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("[TB] FAIL %s inst%0d t=%0t actual=%h required=%h", name, inst, $time, act, req);
        end
    endtask

    task automatic check_inst(input int inst, input exp_t e, input exp_t a);
        exp_t r;
        r = rst ? e : '0;
        cmp("key_on", inst, a.on, r.on);
        cmp("key_press", inst, a.press, r.press);
        cmp("key_release", inst, a.rel, r.rel);
        cmp("any_key", inst, {7'd0, a.any}, {7'd0, r.any});
        cmp("active_idx", inst, {4'd0, a.idx}, {4'd0, r.idx});
        if (a.press != 0 || a.rel != 0)
            $display("[TB] t=%0t inst%0d press=%b release=%b key_on=%b", $time, inst, a.press, a.rel, a.on);
    endtask

    always @(negedge clk) begin
        if (q_hi.size() == 0 || q_lo.size() == 0) begin
            tests++;
            fails++;
            $display("[TB] FAIL queue_empty t=%0t actual=%0d required=1", $time, q_hi.size());
        end else begin
            check_inst(0, q_hi.pop_front(), {on_hi, press_hi, rel_hi, any_hi, idx_hi});
            check_inst(1, q_lo.pop_front(), {on_lo, press_lo, rel_lo, any_lo, idx_lo});
        end
    end

    // ---------------- stimulus ----------------
    int hold_hi [8];
    int hold_lo [8];

    task automatic random_phase(input int cycles);
        for (int n = 0; n < cycles; n++) begin
            @(negedge clk);
            for (int c = 0; c < 8; c++) begin
                if (hold_hi[c] == 0) begin
                    raw_hi[c]  = ~raw_hi[c];
                    hold_hi[c] = $urandom_range(1, 12);
                end else begin
                    hold_hi[c]--;
                end
                if (hold_lo[c] == 0) begin
                    raw_lo[c]  = ~raw_lo[c];
                    hold_lo[c] = $urandom_range(1, 5);
                end else begin
                    hold_lo[c]--;
                end
            end
        end
    endtask

    initial begin
        for (int c = 0; c < 8; c++) begin
            hold_hi[c] = 0;
            hold_lo[c] = 0;
        end
        // Reset held with all sensors active on the active-high instance.
        repeat (10) @(negedge clk);
        rst = 1'b1;
        repeat (20) @(negedge clk);
        // Active-low instance: press key 0 by pulling it low.
        raw_lo = 8'hFE;
        repeat (10) @(negedge clk);
        raw_hi = 8'h00;
        raw_lo = 8'hFF;
        repeat (15) @(negedge clk);
        random_phase(3000);

        // Reset in the middle of a count: keys 4..7 are held, and key 1 is arming with cnt=2.
        @(negedge clk);
        raw_hi = 8'hF0;
        raw_lo = 8'hFF;
        repeat (20) @(negedge clk);
        raw_hi = 8'hF2;
        repeat (5) @(posedge clk);
        #2 rst = 1'b0;
        #1;
        tests++;
        if (on_hi !== 8'h00 || any_hi !== 1'b0 || idx_hi !== 4'd0 || press_hi !== 8'h00) begin
            fails++;
            $display("[TB] FAIL async_reset t=%0t actual=%h required=00", $time, on_hi);
        end
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (20) @(negedge clk);
        random_phase(500);
        repeat (5) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
